// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS-subset controller and its ALU:
// controller state encoding, ALU control codes, opcode and funct constants.
package mips_pkg;

    localparam int unsigned ADDR_W     = 32;  // datapath width, informational
    localparam int unsigned ALU_CTRL_W = 4;
    localparam int unsigned OP_W       = 6;
    localparam int unsigned STATE_W    = 4;
    localparam int unsigned ALU_OP_W   = 2;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE    = 4'd0,
        S_FETCH   = 4'd1,
        S_DECODE  = 4'd2,
        S_MEMADR  = 4'd3,
        S_MEMRD   = 4'd4,
        S_MEMWB   = 4'd5,
        S_MEMWR   = 4'd6,
        S_RTYPEEX = 4'd7,
        S_RTYPEWB = 4'd8,
        S_BEQEX   = 4'd9,
        S_ADDIEX  = 4'd10,
        S_ADDIWB  = 4'd11,
        S_JEX     = 4'd12,
        S_TRAP    = 4'd13
    } state_t;

    // ALU control codes, shared with the ALU
    localparam logic [ALU_CTRL_W-1:0] ALU_AND = 4'b0000;
    localparam logic [ALU_CTRL_W-1:0] ALU_OR  = 4'b0001;
    localparam logic [ALU_CTRL_W-1:0] ALU_ADD = 4'b0010;
    localparam logic [ALU_CTRL_W-1:0] ALU_SUB = 4'b0110;
    localparam logic [ALU_CTRL_W-1:0] ALU_SLT = 4'b0111;
    localparam logic [ALU_CTRL_W-1:0] ALU_NOR = 4'b1100;

    localparam logic [OP_W-1:0] OP_R    = 6'b000000;
    localparam logic [OP_W-1:0] OP_LW   = 6'b100011;
    localparam logic [OP_W-1:0] OP_SW   = 6'b101011;
    localparam logic [OP_W-1:0] OP_BEQ  = 6'b000100;
    localparam logic [OP_W-1:0] OP_ADDI = 6'b001000;
    localparam logic [OP_W-1:0] OP_J    = 6'b000010;

    localparam logic [OP_W-1:0] FN_ADD = 6'b100000;
    localparam logic [OP_W-1:0] FN_SUB = 6'b100010;
    localparam logic [OP_W-1:0] FN_AND = 6'b100100;
    localparam logic [OP_W-1:0] FN_OR  = 6'b100101;
    localparam logic [OP_W-1:0] FN_SLT = 6'b101010;
    localparam logic [OP_W-1:0] FN_NOR = 6'b100111;

    // Controller request to the ALU decoder
    localparam logic [ALU_OP_W-1:0] ALUOP_ADD   = 2'b00;
    localparam logic [ALU_OP_W-1:0] ALUOP_SUB   = 2'b01;
    localparam logic [ALU_OP_W-1:0] ALUOP_FUNCT = 2'b10;

endpackage

// File: rtl/mc_control_if.sv
// Controller <-> datapath bundle.
// master: controller side (takes opcode/funct/zero, drives enables and selects).
// slave : datapath side.
interface mc_control_if;
    import mips_pkg::*;

    logic [OP_W-1:0]       opcode;
    logic [OP_W-1:0]       funct;
    logic                  zero;
    logic                  pc_en;
    logic                  iord;
    logic                  mem_read;
    logic                  mem_write;
    logic                  ir_write;
    logic                  mem_to_reg;
    logic                  reg_dst;
    logic                  reg_write;
    logic                  alu_src_a;
    logic [1:0]            alu_src_b;
    logic [1:0]            pc_src;
    logic [ALU_CTRL_W-1:0] alu_control;
    logic                  illegal;
    logic [STATE_W-1:0]    state_dbg;

    modport master (
        input  opcode, funct, zero,
        output pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
               reg_write, alu_src_a, alu_src_b, pc_src, alu_control, illegal,
               state_dbg
    );

    modport slave (
        output opcode, funct, zero,
        input  pc_en, iord, mem_read, mem_write, ir_write, mem_to_reg, reg_dst,
               reg_write, alu_src_a, alu_src_b, pc_src, alu_control, illegal,
               state_dbg
    );

endinterface

// File: rtl/alu_decode.sv
// ALU control decoder (combinational).
// Ports: funct (IR[5:0]), alu_op (request from controller) ->
//        alu_control (ALU code), funct_legal (0 for an unsupported funct).
// An unsupported funct yields ADD so the datapath sees a benign operation.
module alu_decode
    import mips_pkg::*;
(
    input  logic [OP_W-1:0]       funct,
    input  logic [ALU_OP_W-1:0]   alu_op,
    output logic [ALU_CTRL_W-1:0] alu_control,
    output logic                  funct_legal
);

    always_comb begin
        alu_control = ALU_ADD;
        funct_legal = 1'b1;
        case (alu_op)
            ALUOP_SUB:   alu_control = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alu_control = ALU_ADD;
                    FN_SUB:  alu_control = ALU_SUB;
                    FN_AND:  alu_control = ALU_AND;
                    FN_OR:   alu_control = ALU_OR;
                    FN_SLT:  alu_control = ALU_SLT;
                    FN_NOR:  alu_control = ALU_NOR;
                    default: funct_legal = 1'b0;
                endcase
            end
            default: alu_control = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mc_control.sv
// Multicycle main controller for the single-ALU MIPS-subset datapath.
// Ports: clk, rst_n (async, active-low), bus (mc_control_if.master):
//   in : opcode, funct, zero
//   out: datapath enables, mux selects, alu_control, illegal pulse, state_dbg
// Outputs are Moore-decoded from the state register, so an asynchronous reset
// clears them immediately; pc_en in BEQEX follows the zero input directly.
module mc_control
    import mips_pkg::*;
(
    input  logic         clk,
    input  logic         rst_n,
    mc_control_if.master bus
);

    state_t                state;
    state_t                state_next;
    logic [ALU_OP_W-1:0]   alu_op;
    logic [ALU_CTRL_W-1:0] dec_ctrl;
    logic                  funct_legal;

    // ALU request per state; everything except R-type and BEQ adds
    assign alu_op = (state == S_RTYPEEX) ? ALUOP_FUNCT :
                    (state == S_BEQEX)   ? ALUOP_SUB   : ALUOP_ADD;

    alu_decode u_alu_decode (
        .funct       (bus.funct),
        .alu_op      (alu_op),
        .alu_control (dec_ctrl),
        .funct_legal (funct_legal)
    );

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= S_IDLE;
        else        state <= state_next;
    end

    // Next-state logic
    always_comb begin
        state_next = S_FETCH;
        case (state)
            S_IDLE:   state_next = S_FETCH;
            S_FETCH:  state_next = S_DECODE;
            S_DECODE: begin
                case (bus.opcode)
                    OP_LW, OP_SW: state_next = S_MEMADR;
                    OP_R:         state_next = S_RTYPEEX;
                    OP_BEQ:       state_next = S_BEQEX;
                    OP_ADDI:      state_next = S_ADDIEX;
                    OP_J:         state_next = S_JEX;
                    default:      state_next = S_TRAP;
                endcase
            end
            S_MEMADR:  state_next = (bus.opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            S_MEMRD:   state_next = S_MEMWB;
            S_RTYPEEX: state_next = funct_legal ? S_RTYPEWB : S_TRAP;
            S_ADDIEX:  state_next = S_ADDIWB;
            default:   state_next = S_FETCH;
        endcase
    end

    // Output decode
    always_comb begin
        bus.pc_en       = 1'b0;
        bus.iord        = 1'b0;
        bus.mem_read    = 1'b0;
        bus.mem_write   = 1'b0;
        bus.ir_write    = 1'b0;
        bus.mem_to_reg  = 1'b0;
        bus.reg_dst     = 1'b0;
        bus.reg_write   = 1'b0;
        bus.alu_src_a   = 1'b0;
        bus.alu_src_b   = 2'b00;
        bus.pc_src      = 2'b00;
        bus.alu_control = '0;
        bus.illegal     = 1'b0;
        bus.state_dbg   = state;
        case (state)
            S_FETCH: begin
                bus.mem_read    = 1'b1;
                bus.ir_write    = 1'b1;
                bus.alu_src_b   = 2'b01;
                bus.alu_control = dec_ctrl;
                bus.pc_en       = 1'b1;
            end
            S_DECODE: begin
                bus.alu_src_b   = 2'b11;
                bus.alu_control = dec_ctrl;
            end
            S_MEMADR, S_ADDIEX: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_src_b   = 2'b10;
                bus.alu_control = dec_ctrl;
            end
            S_MEMRD: begin
                bus.mem_read = 1'b1;
                bus.iord     = 1'b1;
            end
            S_MEMWB: begin
                bus.reg_write  = 1'b1;
                bus.mem_to_reg = 1'b1;
            end
            S_MEMWR: begin
                bus.mem_write = 1'b1;
                bus.iord      = 1'b1;
            end
            S_RTYPEEX: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = dec_ctrl;
            end
            S_RTYPEWB: begin
                bus.reg_write = 1'b1;
                bus.reg_dst   = 1'b1;
            end
            S_BEQEX: begin
                bus.alu_src_a   = 1'b1;
                bus.alu_control = dec_ctrl;
                bus.pc_src      = 2'b01;
                bus.pc_en       = bus.zero;
            end
            S_ADDIWB: bus.reg_write = 1'b1;
            S_JEX: begin
                bus.pc_src = 2'b10;
                bus.pc_en  = 1'b1;
            end
            S_TRAP:  bus.illegal = 1'b1;
            default: bus.illegal = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_mc_control.sv
// Self-checking bench for mc_control: directed instructions, random
// instruction stream and a mid-instruction reset, compared cycle by cycle
// against an instruction-level model of the expected control words.
module tb_mc_control;
    import mips_pkg::*;

    typedef struct packed {
        logic       pc_en;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       mem_to_reg;
        logic       reg_dst;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        logic [3:0] alu_control;
        logic       illegal;
        logic [3:0] state;
    } word_t;

    typedef word_t wq_t[$];

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;

    logic [5:0] legal_ops [6] = '{6'b000000, 6'b100011, 6'b101011,
                                  6'b000100, 6'b001000, 6'b000010};
    logic [5:0] legal_fns [6] = '{6'b100000, 6'b100010, 6'b100100,
                                  6'b100101, 6'b101010, 6'b100111};

    always #5 clk = ~clk;

    mc_control_if bus ();

    mc_control dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic word_t sample();
        word_t w;
        w.pc_en       = bus.pc_en;
        w.iord        = bus.iord;
        w.mem_read    = bus.mem_read;
        w.mem_write   = bus.mem_write;
        w.ir_write    = bus.ir_write;
        w.mem_to_reg  = bus.mem_to_reg;
        w.reg_dst     = bus.reg_dst;
        w.reg_write   = bus.reg_write;
        w.alu_src_a   = bus.alu_src_a;
        w.alu_src_b   = bus.alu_src_b;
        w.pc_src      = bus.pc_src;
        w.alu_control = bus.alu_control;
        w.illegal     = bus.illegal;
        w.state       = bus.state_dbg;
        return w;
    endfunction

    // R-type funct to ALU code; returns 0 for an unsupported funct
    function automatic bit alu_ref(input logic [5:0] fn, output logic [3:0] code);
        code = 4'b0010;
        case (fn)
            6'b100000: code = 4'b0010;
            6'b100010: code = 4'b0110;
            6'b100100: code = 4'b0000;
            6'b100101: code = 4'b0001;
            6'b101010: code = 4'b0111;
            6'b100111: code = 4'b1100;
            default:   return 1'b0;
        endcase
        return 1'b1;
    endfunction

    // Expected control word for every cycle of one instruction
    function automatic wq_t build_seq(input logic [5:0] op, input logic [5:0] fn,
                                      input logic z);
        wq_t        q;
        word_t      w;
        logic [3:0] c;
        bit         ok;
        w = '0; w.pc_en = 1; w.mem_read = 1; w.ir_write = 1; w.alu_src_b = 2'b01;
        w.alu_control = 4'b0010; w.state = S_FETCH; q.push_back(w);
        w = '0; w.alu_src_b = 2'b11; w.alu_control = 4'b0010; w.state = S_DECODE;
        q.push_back(w);
        case (op)
            6'b100011, 6'b101011: begin
                w = '0; w.alu_src_a = 1; w.alu_src_b = 2'b10; w.alu_control = 4'b0010;
                w.state = S_MEMADR; q.push_back(w);
                if (op == 6'b100011) begin
                    w = '0; w.mem_read = 1; w.iord = 1; w.state = S_MEMRD; q.push_back(w);
                    w = '0; w.reg_write = 1; w.mem_to_reg = 1; w.state = S_MEMWB;
                    q.push_back(w);
                end else begin
                    w = '0; w.mem_write = 1; w.iord = 1; w.state = S_MEMWR; q.push_back(w);
                end
            end
            6'b000000: begin
                ok = alu_ref(fn, c);
                w = '0; w.alu_src_a = 1; w.alu_control = c; w.state = S_RTYPEEX;
                q.push_back(w);
                w = '0;
                if (ok) begin w.reg_write = 1; w.reg_dst = 1; w.state = S_RTYPEWB; end
                else    begin w.illegal = 1; w.state = S_TRAP; end
                q.push_back(w);
            end
            6'b000100: begin
                w = '0; w.alu_src_a = 1; w.alu_control = 4'b0110; w.pc_src = 2'b01;
                w.pc_en = z; w.state = S_BEQEX; q.push_back(w);
            end
            6'b001000: begin
                w = '0; w.alu_src_a = 1; w.alu_src_b = 2'b10; w.alu_control = 4'b0010;
                w.state = S_ADDIEX; q.push_back(w);
                w = '0; w.reg_write = 1; w.state = S_ADDIWB; q.push_back(w);
            end
            6'b000010: begin
                w = '0; w.pc_src = 2'b10; w.pc_en = 1; w.state = S_JEX; q.push_back(w);
            end
            default: begin
                w = '0; w.illegal = 1; w.state = S_TRAP; q.push_back(w);
            end
        endcase
        return q;
    endfunction

    // Entered at a falling edge with the DUT in FETCH; leaves it in FETCH
    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn,
                             input logic z);
        wq_t   q;
        word_t got;
        q = build_seq(op, fn, z);
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
        foreach (q[k]) begin
            got = sample();
            check($sformatf("op%b_fn%b_z%0d_cyc%0d", op, fn, z, k),
                  32'(got), 32'(q[k]));
            check($sformatf("excl_op%b_cyc%0d", op, k),
                  32'({got.mem_read & got.mem_write, got.reg_write & got.mem_write}),
                  32'(0));
            @(negedge clk);
        end
    endtask

    initial begin
        word_t      got;
        logic [5:0] op;
        logic [5:0] fn;

        rst_n      = 1'b0;
        bus.opcode = '0;
        bus.funct  = '0;
        bus.zero   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("reset_cyc%0d", i), 32'(sample()), 32'(0));
        end
        rst_n = 1'b1;
        #1;
        check("idle_after_release", 32'(sample()), 32'(0));
        @(negedge clk);

        run_instr(6'b000000, 6'b100010, 1'b0);  // sub
        run_instr(6'b100011, 6'b000000, 1'b0);  // lw
        run_instr(6'b000100, 6'b000000, 1'b1);  // beq taken
        run_instr(6'b000100, 6'b000000, 1'b0);  // beq not taken
        run_instr(6'b111111, 6'b000000, 1'b0);  // illegal opcode
        run_instr(6'b000000, 6'b000000, 1'b0);  // illegal funct
        run_instr(6'b101011, 6'b000000, 1'b1);  // sw
        run_instr(6'b001000, 6'b101010, 1'b0);  // addi
        run_instr(6'b000010, 6'b100111, 1'b1);  // j

        for (int i = 0; i < 80; i++) begin
            case ($urandom_range(0, 7))
                6:       op = 6'($urandom);
                7:       op = 6'b000000;
                default: op = legal_ops[$urandom_range(0, 5)];
            endcase
            if ($urandom_range(0, 3) != 0) fn = legal_fns[$urandom_range(0, 5)];
            else                           fn = 6'($urandom);
            run_instr(op, fn, 1'($urandom));
        end

        // Reset asserted in the middle of a store
        bus.opcode = 6'b101011;
        repeat (3) @(negedge clk);
        got = sample();
        check("memwr_before_reset", 32'({got.mem_write, got.state}),
              32'({1'b1, 4'(S_MEMWR)}));
        #2 rst_n = 1'b0;
        #1;
        got = sample();
        check("memwr_async_reset_wr", 32'(got.mem_write), 32'(0));
        check("memwr_async_reset_all", 32'(got), 32'(0));
        repeat (2) @(negedge clk);
        check("held_in_reset", 32'(sample()), 32'(0));
        rst_n = 1'b1;
        #1;
        check("idle_after_rerelease", 32'(sample()), 32'(0));
        @(negedge clk);
        run_instr(6'b001000, 6'b000000, 1'b0);
        run_instr(6'b000000, 6'b100101, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
